sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Responder side of the MEM-stage data-memory interface. Accepts one 32-bit load or store per request from the MEM stage and performs it on an external 16-bit asynchronous SRAM as two half-word accesses.
- Drives ready low while busy. The pipeline derives its freeze from this signal, which holds the stage registers.
- Sits between the MEM stage and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.
- HALF_CYCLES, 3: clock cycles per half-word access; minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from the MEM stage.
- wr_en  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data.
- read_data  out  32  load result, registered.
- ready  out  1  high = no transaction pending or transaction complete this cycle.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  data driven to the SRAM.
- sram_dq_in  in  16  data returned from the SRAM.
- sram_dq_oe  out  1  top-level tristate enable for sram_dq_out.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A cycle counter cnt runs 0..HALF_CYCLES-1.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and cnt to 0.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - A transaction in flight is abandoned. There is no partial write-back beyond half-words already strobed.
- Address map:
  - word = (address - BASE_ADDR) >> 2, computed modulo 2^32.
  - LOW phase sram_addr = {word[SRAM_AW-2:0], 1'b0}; HIGH phase uses the same with LSB 1.
  - Upper bits are truncated, so out-of-range addresses wrap silently.
- IDLE:
  - With no request, ready=1.
  - When rd_en or wr_en is high: ready=0 combinationally in the same cycle. The op, address and write_data are latched, and the next state is LOW with cnt=0.
  - If rd_en and wr_en are both high, the request is treated as a write.
- LOW and HIGH phases:
  - Each phase lasts exactly HALF_CYCLES cycles; ready=0 throughout.
  - sram_addr is stable for the whole phase.
  - Write: sram_dq_oe=1. sram_dq_out carries latched write_data[15:0] in LOW and [31:16] in HIGH. sram_we_n=0 for cnt < HALF_CYCLES-1 and 1 on the last cycle, giving address/data hold. sram_oe_n=1.
  - Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0. On the last cycle of LOW, sram_dq_in is captured into a low-half holding register. On the last cycle of HIGH, read_data <= {sram_dq_in, low_half}.
  - LOW goes to HIGH, and HIGH goes to DONE, when cnt == HALF_CYCLES-1.
- DONE:
  - Lasts exactly 1 cycle with ready=1, so the pipeline advances; next state is IDLE.
  - All SRAM strobes are inactive and sram_dq_oe=0.
- Latency: with the request first seen in cycle 0, ready=0 for cycles 0..2*HALF_CYCLES and ready=1 in cycle 2*HALF_CYCLES+1. With the default, that is 7 stalled cycles followed by 1 ready cycle.
- read_data holds its value until the next read completes; writes never alter it.
- Requests are only sampled in IDLE. Input changes during LOW/HIGH/DONE are ignored.
- A request present in the cycle after DONE starts a new transaction, so back-to-back accesses are 2*HALF_CYCLES+2 cycles apart.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> ready=1, read_data=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
- Store: wr_en=1, address=1028, write_data=0xDEADBEEF.
  - sram_addr=2 with dq_out=0xBEEF and we_n low for 2 cycles.
  - Then sram_addr=3 with dq_out=0xDEAD.
  - ready low 7 cycles, high on 8th.
- Load after store (SRAM model): rd_en=1, address=1028 -> read_data=0xDEADBEEF in the DONE cycle, and it is held after rd_en drops.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=0x12345678 -> write performed (SRAM words 0,1 = 0x5678,0x1234); read_data unchanged.
- Reset mid-operation: assert rst=0 during the HIGH phase of a store -> all outputs return to reset values immediately and state is IDLE; after release, a new load completes normally in 8 cycles.
- Back-to-back loads at 1024 and 1032 -> second transaction's first SRAM address (4) appears in the cycle after DONE; each ready pulse is exactly 1 cycle.

Source files
------------

// File: rtl/sram_mem_controller.sv
`timescale 1ns/1ps
// MEM-stage load/store responder: one 32-bit access as two half-word cycles on a 16-bit async SRAM.
// Latency: ready low for 2*HALF_CYCLES+1 cycles from the request, then high for one DONE cycle.
// Backpressure: ready drops combinationally on a request in IDLE; inputs are ignored until IDLE returns.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          HALF_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               op_wr;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [15:0]        low_half;
  logic               req;
  logic               last;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_in;
  logic               unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign last   = (cnt == CNT_LAST);
  // Subtraction wraps modulo 2^32; bits above the SRAM range are dropped.
  assign offset  = address - BASE_ADDR;
  assign word_in = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        ready   = !req;
        cnt_nxt = '0;
        if (req) begin
          state_nxt = LOW;
          // Present the low half-word address a cycle early for setup.
          sram_addr = {word_in, 1'b0};
        end
      end
      LOW, HIGH: begin
        sram_addr = {word_q, (state == HIGH)};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
          // Strobe released on the final cycle to give address/data hold.
          sram_we_n   = last;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = (state == LOW) ? HIGH : DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      low_half  <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr   <= wr_en;
        word_q  <= word_in;
        wdata_q <= write_data;
      end
      if (state == LOW && !op_wr && last)
        low_half <= sram_dq_in;
      if (state == HIGH && !op_wr && last)
        read_data <= {sram_dq_in, low_half};
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
`timescale 1ns/1ps
// Directed bench for sram_mem_controller with a behavioural 16-bit SRAM model.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:63];
  logic        preload = 1'b1;
  logic        exp_rdy;
  logic        exp_we;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;

  sram_mem_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      mem[4] <= 16'h0BAD;
      mem[5] <= 16'hCAFE;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    preload = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h expected 0", read_data); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b expected 1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b expected 1", sram_oe_n); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe got %b expected 0", sram_dq_oe); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_sram_addr got %h expected 0", sram_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = (c == 7);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL store_ready c=%0d got %b expected %b", c, ready, exp_rdy); end
      if (c >= 1 && c <= 6) begin
        exp_addr = (c <= 3) ? 18'd2 : 18'd3;
        exp_dq   = (c <= 3) ? 16'hBEEF : 16'hDEAD;
        exp_we   = (c == 3 || c == 6);
        checks++; if (sram_addr !== exp_addr) begin errors++; $display("FAIL store_addr c=%0d got %0d expected %0d", c, sram_addr, exp_addr); end
        checks++; if (sram_dq_out !== exp_dq) begin errors++; $display("FAIL store_dq c=%0d got %h expected %h", c, sram_dq_out, exp_dq); end
        checks++; if (sram_we_n !== exp_we) begin errors++; $display("FAIL store_we_n c=%0d got %b expected %b", c, sram_we_n, exp_we); end
        checks++; if (sram_dq_oe !== 1'b1) begin errors++; $display("FAIL store_dq_oe c=%0d got %b expected 1", c, sram_dq_oe); end
        checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL store_oe_n c=%0d got %b expected 1", c, sram_oe_n); end
      end
      @(posedge clk); #1;
      if (c == 0) begin wr_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0; end
    end
    checks++; if (mem[2] !== 16'hBEEF) begin errors++; $display("FAIL store_mem2 got %h expected beef", mem[2]); end
    checks++; if (mem[3] !== 16'hDEAD) begin errors++; $display("FAIL store_mem3 got %h expected dead", mem[3]); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL store_read_data got %h expected 0", read_data); end
  endtask

  task automatic test_load();
    rd_en = 1'b1; address = 32'd1028;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = (c == 7);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL load_ready c=%0d got %b expected %b", c, ready, exp_rdy); end
      if (c >= 1 && c <= 6) begin
        checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL load_oe_n c=%0d got %b expected 0", c, sram_oe_n); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL load_we_n c=%0d got %b expected 1", c, sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL load_dq_oe c=%0d got %b expected 0", c, sram_dq_oe); end
      end
      if (c == 7) begin
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h expected deadbeef", read_data); end
      end
      @(posedge clk); #1;
      if (c == 0) begin rd_en = 1'b0; address = 32'h5555_0000; end
    end
    @(negedge clk);
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold got %h expected deadbeef", read_data); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_idle_ready got %b expected 1", ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = (c == 7);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL simul_ready c=%0d got %b expected %b", c, ready, exp_rdy); end
      @(posedge clk); #1;
      if (c == 0) begin rd_en = 1'b0; wr_en = 1'b0; end
    end
    @(negedge clk);
    checks++; if (mem[0] !== 16'h5678) begin errors++; $display("FAIL simul_mem0 got %h expected 5678", mem[0]); end
    checks++; if (mem[1] !== 16'h1234) begin errors++; $display("FAIL simul_mem1 got %h expected 1234", mem[1]); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL simul_read_data got %h expected deadbeef", read_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_busy c=%0d got %b expected 0", c, ready); end
      if (c < 5) begin
        @(posedge clk); #1;
        if (c == 0) wr_en = 1'b0;
      end
    end
    checks++; if (sram_addr !== 18'd9) begin errors++; $display("FAIL midrst_high_addr got %0d expected 9", sram_addr); end
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_high_we_n got %b expected 0", sram_we_n); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL midrst_read_data got %h expected 0", read_data); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL midrst_addr got %h expected 0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL midrst_dq_out got %h expected 0", sram_dq_out); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL midrst_dq_oe got %b expected 0", sram_dq_oe); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL midrst_we_n got %b expected 1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL midrst_oe_n got %b expected 1", sram_oe_n); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (mem[8] !== 16'h5555) begin errors++; $display("FAIL midrst_mem8 got %h expected 5555", mem[8]); end
    rd_en = 1'b1; address = 32'd1028;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = (c == 7);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL midrst_load_ready c=%0d got %b expected %b", c, ready, exp_rdy); end
      if (c == 7) begin
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_load_data got %h expected deadbeef", read_data); end
      end
      @(posedge clk); #1;
      if (c == 0) rd_en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp_rdy = (c == 7 || c == 15 || c == 16);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c=%0d got %b expected %b", c, ready, exp_rdy); end
      if (c == 1) begin
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL b2b_first_addr got %0d expected 0", sram_addr); end
      end
      if (c == 7) begin
        checks++; if (read_data !== 32'h12345678) begin errors++; $display("FAIL b2b_data0 got %h expected 12345678", read_data); end
      end
      if (c == 8 || c == 9) begin
        checks++; if (sram_addr !== 18'd4) begin errors++; $display("FAIL b2b_second_addr c=%0d got %0d expected 4", c, sram_addr); end
      end
      if (c == 9) begin
        checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL b2b_second_oe_n got %b expected 0", sram_oe_n); end
      end
      if (c == 15) begin
        checks++; if (read_data !== 32'hCAFE0BAD) begin errors++; $display("FAIL b2b_data1 got %h expected cafe0bad", read_data); end
      end
      @(posedge clk); #1;
      if (c == 6) address = 32'd1032;
      if (c == 8) rd_en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
